// File: rtl/ad_avg_protect.sv
// ---------------------------------------------------------------------------
// ad_avg_protect
//
// Paces an external ADC serial reader with a fixed-rate conversion trigger,
// block-averages 2^AVG_SHIFT results and raises an over-limit protection flag
// after TRIP_CNT consecutive averages above trip_level. A conversion that
// does not return data within TIMEOUT cycles of its trigger is abandoned and
// reported on adc_err.
//
// Build option:
//   FAULT_LATCH_EN  defined   -> fault is sticky until fault_clr.
//                   undefined -> fault follows the trip counter and clears on
//                                the first in-limit average; fault_clr unused.
//
// Ports:
//   clk          in   system clock (40 MHz nominal)
//   rst_n        in   asynchronous active-low reset
//   en           in   allows new conversions to start
//   AD_trigger   out  4-cycle conversion request to the reader
//   sample_data  in   12-bit conversion result
//   data_valid   in   one-cycle strobe qualifying sample_data
//   trip_level   in   unsigned over-limit threshold
//   fault_clr    in   fault clear request (latched build only)
//   avg_data     out  latest block average
//   avg_valid    out  one-cycle strobe on avg_data update
//   fault        out  over-limit protection flag
//   adc_err      out  one-cycle strobe on conversion timeout
// ---------------------------------------------------------------------------
module ad_avg_protect #(
  parameter int TRIG_PERIOD = 799,
  parameter int AVG_SHIFT   = 3,
  parameter int TRIP_CNT    = 3,
  parameter int TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        AD_trigger,
  input  logic [11:0] sample_data,
  input  logic        data_valid,
  input  logic [11:0] trip_level,
  input  logic        fault_clr,
  output logic [11:0] avg_data,
  output logic        avg_valid,
  output logic        fault,
  output logic        adc_err
);

  localparam int PW    = (TRIG_PERIOD > 0) ? $clog2(TRIG_PERIOD + 1) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int CW    = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  localparam int ACC_W = 12 + AVG_SHIFT;
  localparam int TCW   = (TRIP_CNT > 0) ? $clog2(TRIP_CNT + 1) : 1;

  localparam logic [PW-1:0]  PERIOD_LAST = PW'(TRIG_PERIOD);
  localparam logic [TW-1:0]  TRIG_LAST   = TW'(3);
  localparam logic [TW-1:0]  TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_LAST    = CW'((1 << AVG_SHIFT) - 1);
  localparam logic [TCW-1:0] TRIP_MAX    = TCW'(TRIP_CNT);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      period_q, period_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [11:0]        avg_q, avg_d;
  logic               avg_valid_q, avg_valid_d;
  logic               adc_err_q, adc_err_d;
  logic [TCW-1:0]     trip_q, trip_d;
  logic               fault_q, fault_d;

  logic               sample_hit, timeout_hit, block_done, trip_hit;
  logic [ACC_W-1:0]   acc_sum;
  logic [11:0]        avg_new;
  logic [TCW-1:0]     trip_next;

  // State register and all datapath registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      tmo_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      adc_err_q   <= 1'b0;
      trip_q      <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      tmo_q       <= tmo_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      adc_err_q   <= adc_err_d;
      trip_q      <= trip_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic. A period start that finds the FSM busy is skipped.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (period_q == '0 && en) state_d = S_TRIG;
      S_TRIG:  if (tmo_q == TRIG_LAST)   state_d = S_WAIT;
      S_WAIT:  if (data_valid || tmo_q == TMO_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    AD_trigger = (state_q == S_TRIG);
  end

  // Counters, accumulator and protection logic.
  always_comb begin
    period_d = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
    // Held at 0 in IDLE, so it reads 0 on the first TRIG cycle.
    tmo_d    = (state_q == S_IDLE) ? '0 : tmo_q + 1'b1;

    sample_hit  = (state_q == S_WAIT) && data_valid;
    timeout_hit = (state_q == S_WAIT) && !data_valid && (tmo_q == TMO_LAST);
    block_done  = sample_hit && (cnt_q == CNT_LAST);

    // 2^AVG_SHIFT * 4095 < 2^ACC_W, so the full block sum always fits.
    acc_sum = acc_q + ACC_W'(sample_data);
    avg_new = acc_sum[ACC_W-1:AVG_SHIFT];

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = block_done;
    adc_err_d   = timeout_hit;
    if (block_done) begin
      acc_d = '0;
      cnt_d = '0;
      avg_d = avg_new;
    end else if (sample_hit) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + 1'b1;
    end

    // Trip counter and fault update on the same edge that publishes the new
    // average, so fault is already valid alongside avg_valid.
    trip_next = trip_q;
    if (block_done) begin
      if (avg_new > trip_level)
        trip_next = (trip_q == TRIP_MAX) ? trip_q : trip_q + 1'b1;
      else
        trip_next = '0;
    end
    trip_hit = block_done && (trip_next == TRIP_MAX);
    trip_d   = trip_next;
`ifdef FAULT_LATCH_EN
    fault_d = fault_q | trip_hit;
    // A trip arriving with the clear wins: the new fault must not be lost.
    if (fault_clr && !trip_hit) begin
      fault_d = 1'b0;
      trip_d  = '0;
    end
`else
    fault_d = block_done ? trip_hit : fault_q;
`endif
  end

`ifndef FAULT_LATCH_EN
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
`endif

  assign avg_data  = avg_q;
  assign avg_valid = avg_valid_q;
  assign fault     = fault_q;
  assign adc_err   = adc_err_q;

endmodule
